// File: rtl/top_pkg.sv
// Shared types for the serial struct link: the payload struct, its reset
// constant, the deserializer FSM state type and an even-parity helper.
package top_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } my_struct_t;

    localparam my_struct_t MyParameter = '{a: 1'b1, b: 1'b0, c: 1'b1, d: 1'b0};

    localparam int FRAME_BITS = $bits(my_struct_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } deser_state_e;

    // Parity bit that makes the total number of ones over a..d plus the bit even.
    function automatic logic even_parity(input my_struct_t s);
        return ^s;
    endfunction

endpackage

// File: rtl/struct_deserializer_fifo.sv
// struct_fifo: small FIFO of my_struct_t with registered head, valid and full
// flags. Pointers carry one extra MSB to tell full from empty.
module struct_fifo
    import top_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  my_struct_t din_i,
    input  logic       pop_i,
    output logic       valid_o,
    output logic       full_o,
    output my_struct_t dout_o
);

    localparam int AW = $clog2(DEPTH);

    my_struct_t        mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    my_struct_t        dout_q, dout_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push_i && !full_q;
    assign do_pop_s  = pop_i && valid_q;

    // Next pointers, flags and head; a push into an emptying FIFO bypasses memory.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        if (!valid_d) begin
            dout_d = dout_q;
        end else if (do_push_s && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
            dout_d = din_i;
        end else begin
            dout_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Pointer and flag state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign dout_o  = dout_q;

endmodule

// File: rtl/struct_deserializer.sv
// Reassembles one my_struct_t per bit-serial frame (a,b,c,d MSB first) and
// buffers it in struct_fifo. Define STRUCT_DESER_PARITY_EN for a trailing even-parity bit.
module struct_deserializer
    import top_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter my_struct_t RESET_VALUE = MyParameter
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_valid_i,
    output logic       ser_ready_o,
    input  logic       ser_sof_i,
    input  logic       ser_data_i,
    output logic       struct_valid_o,
    input  logic       struct_ready_i,
    output my_struct_t struct_o,
    output my_struct_t last_struct_o,
    output logic       frame_err_o
);

    localparam logic [1:0] LAST_CNT = 2'(FRAME_BITS - 1);

    deser_state_e            state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    my_struct_t              last_q, last_d;
    logic                    err_q, err_d;
    logic                    fifo_full_s;
    logic                    push_s;
    my_struct_t              push_data_s;
    logic                    xfer_s;

    assign xfer_s = ser_valid_i && !fifo_full_s;

    // Frame FSM: sof always restarts at field a; a stray sof or bad parity flags an error.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        err_d       = 1'b0;
        push_s      = 1'b0;
        push_data_s = my_struct_t'(shreg_q);
        if (xfer_s) begin
            case (state_q)
                IDLE: begin
                    if (ser_sof_i) begin
                        shreg_d = {ser_data_i, {(FRAME_BITS-1){1'b0}}};
                        cnt_d   = 2'd1;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (ser_sof_i) begin
                        err_d   = 1'b1;
                        shreg_d = {ser_data_i, {(FRAME_BITS-1){1'b0}}};
                        cnt_d   = 2'd1;
                    end else begin
                        shreg_d[LAST_CNT - cnt_q] = ser_data_i;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d = 2'd0;
`ifdef STRUCT_DESER_PARITY_EN
                            state_d = CHECK;
`else
                            push_s      = 1'b1;
                            push_data_s = my_struct_t'({shreg_q[FRAME_BITS-1:1], ser_data_i});
                            last_d      = my_struct_t'({shreg_q[FRAME_BITS-1:1], ser_data_i});
                            state_d     = IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
`ifdef STRUCT_DESER_PARITY_EN
                CHECK: begin
                    if (ser_sof_i) begin
                        err_d   = 1'b1;
                        shreg_d = {ser_data_i, {(FRAME_BITS-1){1'b0}}};
                        cnt_d   = 2'd1;
                        state_d = SHIFT;
                    end else if (ser_data_i == even_parity(my_struct_t'(shreg_q))) begin
                        push_s  = 1'b1;
                        last_d  = my_struct_t'(shreg_q);
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, assembly register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            shreg_q <= '0;
            last_q  <= RESET_VALUE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    struct_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   (push_data_s),
        .pop_i   (struct_ready_i),
        .valid_o (struct_valid_o),
        .full_o  (fifo_full_s),
        .dout_o  (struct_o)
    );

    assign ser_ready_o   = !fifo_full_s;
    assign last_struct_o = last_q;
    assign frame_err_o   = err_q;

endmodule

// File: tb/tb_struct_deserializer.sv
// Self-checking bench for struct_deserializer: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based frame model.
module tb_struct_deserializer;
    import top_pkg::*;

    localparam int DEPTH = 4;
`ifdef STRUCT_DESER_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_valid_i = 1'b0;
    logic       ser_ready_o;
    logic       ser_sof_i = 1'b0;
    logic       ser_data_i = 1'b0;
    logic       struct_valid_o;
    logic       struct_ready_i = 1'b0;
    my_struct_t struct_o;
    my_struct_t last_struct_o;
    logic       frame_err_o;

    always #5 clk = ~clk;

    struct_deserializer #(
        .FIFO_DEPTH  (DEPTH),
        .RESET_VALUE (MyParameter)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ser_valid_i    (ser_valid_i),
        .ser_ready_o    (ser_ready_o),
        .ser_sof_i      (ser_sof_i),
        .ser_data_i     (ser_data_i),
        .struct_valid_o (struct_valid_o),
        .struct_ready_i (struct_ready_i),
        .struct_o       (struct_o),
        .last_struct_o  (last_struct_o),
        .frame_err_o    (frame_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: accepted bits of the open frame, the FIFO contents, and visible outputs.
    logic [3:0] m_q[$];
    bit         m_bits[$];
    logic [3:0] m_last = 4'b1010;
    logic [3:0] m_head = 4'h0;
    logic       m_err  = 1'b0;

    function automatic bit m_ready();
        return m_q.size() < DEPTH;
    endfunction

    task automatic model_edge();
        bit         acc;
        bit         pop;
        bit         done;
        logic [3:0] fr;
        if (rst) begin
            m_q.delete();
            m_bits.delete();
            m_last = 4'b1010;
            m_head = 4'h0;
            m_err  = 1'b0;
            return;
        end
        acc    = ser_valid_i && m_ready();
        pop    = (m_q.size() > 0) && struct_ready_i;
        done   = 1'b0;
        fr     = 4'h0;
        m_err  = 1'b0;
        if (acc) begin
            if (m_bits.size() == 0) begin
                if (ser_sof_i) m_bits.push_back(ser_data_i);
                else m_err = 1'b1;
            end else if (ser_sof_i) begin
                m_err = 1'b1;
                m_bits.delete();
                m_bits.push_back(ser_data_i);
            end else begin
                m_bits.push_back(ser_data_i);
                if (m_bits.size() == FLEN) begin
                    fr = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
`ifdef STRUCT_DESER_PARITY_EN
                    if (((m_bits[0] + m_bits[1] + m_bits[2] + m_bits[3] + m_bits[4]) % 2) == 0) done = 1'b1;
                    else m_err = 1'b1;
`else
                    done = 1'b1;
`endif
                    m_bits.delete();
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            m_q.push_back(fr);
            m_last = fr;
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic compare_all();
        check_eq("ready", 8'(ser_ready_o), 8'(m_ready()));
        check_eq("valid", 8'(struct_valid_o), 8'(m_q.size() > 0));
        check_eq("head", 8'(struct_o), 8'(m_head));
        check_eq("last", 8'(last_struct_o), 8'(m_last));
        check_eq("err", 8'(frame_err_o), 8'(m_err));
    endtask

    task automatic step(input logic v, input logic s, input logic d, input logic r);
        ser_valid_i    = v;
        ser_sof_i      = s;
        ser_data_i     = d;
        struct_ready_i = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic send_bit(input logic s, input logic d, input logic r);
        bit acc;
        for (int k = 0; k < 64; k++) begin
            acc = m_ready();
            step(1'b1, s, d, r);
            if (acc) return;
        end
        check_eq("accept_timeout", 8'd0, 8'd1);
    endtask

    task automatic send_frame(input logic [3:0] f, input logic r, input logic bad_par);
        send_bit(1'b1, f[3], r);
        send_bit(1'b0, f[2], r);
        send_bit(1'b0, f[1], r);
        send_bit(1'b0, f[0], r);
`ifdef STRUCT_DESER_PARITY_EN
        send_bit(1'b0, (f[3] ^ f[2] ^ f[1] ^ f[0]) ^ bad_par, r);
`else
        if (bad_par) check_eq("parity_unsupported", 8'd0, 8'd1);
`endif
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_last", 8'(last_struct_o), 8'h0A);
        check_eq("rst_valid", 8'(struct_valid_o), 8'h00);
        check_eq("rst_ready", 8'(ser_ready_o), 8'h01);
        check_eq("rst_err", 8'(frame_err_o), 8'h00);
        check_eq("rst_head", 8'(struct_o), 8'h00);

        // Single frame 1,0,1,1 with consumer ready.
        send_frame(4'b1011, 1'b1, 1'b0);
        check_eq("f1_valid", 8'(struct_valid_o), 8'h01);
        check_eq("f1_head", 8'(struct_o), 8'h0B);
        check_eq("f1_last", 8'(last_struct_o), 8'h0B);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill the FIFO with the consumer stalled, then stall a fifth frame.
        for (int i = 1; i <= DEPTH; i++) send_frame(4'(i), 1'b0, 1'b0);
        check_eq("bp_ready", 8'(ser_ready_o), 8'h00);
        check_eq("bp_head", 8'(struct_o), 8'h01);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("bp_hold", 8'(struct_o), 8'h01);
        send_frame(4'h5, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("bp_last", 8'(last_struct_o), 8'h05);
        check_eq("bp_empty", 8'(struct_valid_o), 8'h00);

        // sof on the third bit restarts the frame.
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        check_eq("restart_err", 8'(frame_err_o), 8'h01);
        send_bit(1'b0, 1'b0, 1'b1);
        check_eq("restart_err_clr", 8'(frame_err_o), 8'h00);
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
`ifdef STRUCT_DESER_PARITY_EN
        send_bit(1'b0, 1'b1, 1'b1);
`endif
        check_eq("restart_last", 8'(last_struct_o), 8'h0B);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Bits without sof while idle are dropped with an error pulse.
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0, 1'(i), 1'b1);
            check_eq("idle_err", 8'(frame_err_o), 8'h01);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("idle_nopush", 8'(struct_valid_o), 8'h00);

`ifdef STRUCT_DESER_PARITY_EN
        send_frame(4'b1100, 1'b0, 1'b0);
        check_eq("par_ok_last", 8'(last_struct_o), 8'h0C);
        send_frame(4'b1100, 1'b0, 1'b1);
        check_eq("par_bad_err", 8'(frame_err_o), 8'h01);
        send_frame(4'b0011, 1'b0, 1'b1);
        check_eq("par_bad_last", 8'(last_struct_o), 8'h0C);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Reset in the middle of a frame discards it.
        send_frame(4'h6, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_eq("midrst_last", 8'(last_struct_o), 8'h0A);
        check_eq("midrst_valid", 8'(struct_valid_o), 8'h00);
        send_bit(1'b0, 1'b1, 1'b1);
        check_eq("midrst_idle", 8'(frame_err_o), 8'h01);

        // Randomized traffic with occasional misplaced sof and resets.
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic s;
            v = ($urandom_range(0, 3) != 0);
            s = (m_bits.size() == 0);
            if ($urandom_range(0, 15) == 0) s = ~s;
            rst = ($urandom_range(0, 499) == 0);
            step(v, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/struct_deserializer.md
Name: struct_deserializer

Overview:
- Receiving end of the serial struct link: accepts a bit-serial frame and reassembles one top_pkg::my_struct_t per frame.
- Completed structs are buffered in a small FIFO and presented on a valid/ready output.
- Sits between the serial link pins and any logic consuming my_struct_t. Register-out, single clock domain.

Parameters:
- FIFO_DEPTH, 4, number of assembled structs buffered; power of two, >= 2.
- RESET_VALUE, top_pkg::MyParameter ('{a:1,b:0,c:1,d:0} = 4'b1010), value of last_struct_o after reset.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- ser_valid_i  input  1  serial bit valid.
- ser_ready_o  output  1  deserializer can accept a bit.
- ser_sof_i  input  1  start of frame; qualifies the first bit (field a).
- ser_data_i  input  1  serial data bit, field order a, b, c, d (MSB first).
- struct_valid_o  output  1  FIFO head valid.
- struct_ready_i  input  1  consumer accepts the head.
- struct_o  output  my_struct_t (4)  FIFO head.
- last_struct_o  output  my_struct_t (4)  most recently completed good frame.
- frame_err_o  output  1  one-cycle pulse on a frame violation.

Behaviour:
- Bit transfer occurs on a cycle with ser_valid_i && ser_ready_o.
- ser_ready_o = !fifo_full. It is registered-derived; a pop in the same cycle does not raise it.
- Reset values:
  - ser_ready_o = 1 (FIFO empty).
  - struct_valid_o = 0; struct_o = 0.
  - last_struct_o = RESET_VALUE.
  - frame_err_o = 0.
  - FSM = IDLE; bit counter = 0; FIFO pointers = 0.
- FSM:
  - IDLE: transfer with sof=1 loads bit into a, goes to SHIFT with cnt=1. Transfer with sof=0 is dropped and pulses frame_err_o.
  - SHIFT: each transfer shifts into field cnt and increments cnt. Transfer at cnt=3 completes the frame: push into FIFO, update last_struct_o, go to IDLE (or CHECK when the option is on).
  - Transfer with sof=1 while in SHIFT: pulse frame_err_o, discard the partial frame, restart with this bit as the new a (cnt=1).
- Latency: last bit accepted at cycle N -> struct_valid_o and struct_o valid at N+1 if FIFO was empty; last_struct_o updates at N+1.
- FIFO:
  - Pop on struct_valid_o && struct_ready_i.
  - Simultaneous push and pop is legal when non-empty; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty discrimination.
  - struct_o holds its value while stalled.
- Overflow is impossible by construction: no transfer while full, and the partial frame is held in the FSM.
- rst mid-frame discards the partial frame and FIFO contents and restores all reset values next cycle.

Optional Feature:
- Macro STRUCT_DESER_PARITY_EN.
- Defined:
  - After d, the FSM enters CHECK and consumes one extra bit holding even parity over a..d.
  - On match: push and last_struct_o update happen on this bit, so latency is measured from the parity bit.
  - On mismatch: frame discarded, frame_err_o pulses, no push.
  - sof=1 on the parity bit is treated as a SHIFT-style restart.
- Undefined: 4-bit frames, no CHECK state, no parity logic.

Decomposition:
- top_pkg gains:
  - FRAME_BITS = $bits(my_struct_t).
  - A typedef for the FSM state enum (IDLE, SHIFT, CHECK).
  - A function returning even parity of a my_struct_t.
  - my_struct_t and MyParameter stay in top_pkg.
- Sub-module struct_fifo: parameterised on depth, element type my_struct_t; registered outputs, full/empty flags.

Test Plan:
- Reset then idle -> last_struct_o=4'b1010, struct_valid_o=0, ser_ready_o=1, frame_err_o=0.
- Frame 1,0,1,1 (sof on first), struct_ready_i=1 -> struct_o='{a:1,b:0,c:1,d:1} valid one cycle after 4th bit; last_struct_o=4'b1011.
- struct_ready_i=0, send FIFO_DEPTH=4 frames -> ser_ready_o drops after 4th push. Fifth frame stalls. Raise ready -> four structs pop in order, then the fifth completes.
- sof asserted on bit 3 of a frame -> frame_err_o one-cycle pulse, partial frame not pushed, following 3 bits form a valid frame.
- Bits with sof=0 in IDLE -> each pulses frame_err_o, no push.
- With STRUCT_DESER_PARITY_EN: frame 1,1,0,0 with parity 0 -> pushed. The same frame with parity 1 -> frame_err_o, FIFO unchanged, last_struct_o unchanged.
